writeback_queue: RTL and testbench

Parametrised writeback stage that replaces the single-register stage-4→stage-2 writeback pipe with a DEPTH-entry in-order queue. It sits between the memory stage and the register-file write port. It absorbs cycles where the register-file port is not granted, back-pressuring stage 4 only when full. It also exposes a forwarding lookup over pending writes, so stage 2 can bypass values not yet committed to the register file.

---
 rtl/writeback_queue.sv | 86 ++++++++
 tb/tb_writeback_queue.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order writeback queue between memory stage and register-file write port
// Absorbs un-granted register-file cycles and offers youngest-match forwarding over pending writes.
module writeback_queue #(
   parameter int DATA_W           = 32,
   parameter int REG_W            = 5,
   parameter int DEPTH            = 4,
   parameter int ZERO_REG_DISCARD = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         do_wb_i,
   input  logic [REG_W-1:0]             wb_reg_i,
   input  logic [DATA_W-1:0]            wb_val_i,
   output logic                         wb_ready_o,
   input  logic                         rf_grant_i,
   output logic                         do_wb_o,
   output logic [REG_W-1:0]             wb_reg_o,
   output logic [DATA_W-1:0]            wb_val_o,
   input  logic [REG_W-1:0]             fwd_reg_i,
   output logic                         fwd_hit_o,
   output logic [DATA_W-1:0]            fwd_val_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [REG_W-1:0]  reg_mem [DEPTH];
   logic [DATA_W-1:0] val_mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              full, empty, drop_zero, fwd_zero, enq, deq;
   logic [PTR_W-1:0]  scan_idx;

   assign full       = (count_q == CNT_W'(DEPTH));
   assign empty      = (count_q == '0);
   assign drop_zero  = (ZERO_REG_DISCARD != 0) && (wb_reg_i == '0);
   assign fwd_zero   = (ZERO_REG_DISCARD != 0) && (fwd_reg_i == '0);
   // do_wb_i gates everything else, so unknown payload while idle never reaches state
   assign enq        = do_wb_i && !full && !drop_zero;
   assign deq        = !empty && rf_grant_i;

   assign wb_ready_o = !full;
   assign do_wb_o    = !empty;
   assign wb_reg_o   = empty ? '0 : reg_mem[rd_ptr_q];
   assign wb_val_o   = empty ? '0 : val_mem[rd_ptr_q];
   assign count_o    = count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({enq, deq})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) begin
         reg_mem[wr_ptr_q] <= wb_reg_i;
         val_mem[wr_ptr_q] <= wb_val_i;
      end
   end

   // Walk oldest to youngest so a later match overrides an earlier one
   always_comb begin
      fwd_hit_o = 1'b0;
      fwd_val_o = '0;
      scan_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && !fwd_zero && (reg_mem[scan_idx] == fwd_reg_i)) begin
            fwd_hit_o = 1'b1;
            fwd_val_o = val_mem[scan_idx];
         end
      end
   end

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
// A negedge monitor models the queue contents; scenario tasks add targeted inline checks.
module tb_writeback_queue;

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] v;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        do_wb_i = 1'b0;
   logic [4:0]  wb_reg_i = '0;
   logic [31:0] wb_val_i = '0;
   logic        rf_grant_i = 1'b0;
   logic [4:0]  fwd_reg_i = '0;
   logic        wb_ready_o, do_wb_o, fwd_hit_o;
   logic [4:0]  wb_reg_o;
   logic [31:0] wb_val_o, fwd_val_o;
   logic [2:0]  count_o;
   logic        d0_ready, d0_do_wb, d0_hit;
   logic [4:0]  d0_reg;
   logic [31:0] d0_val, d0_fval;
   logic [2:0]  d0_count;

   ent_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   writeback_queue #(.DATA_W(32), .REG_W(5), .DEPTH(4), .ZERO_REG_DISCARD(1)) dut (
      .clk_i(clk), .rst_i(rst_i), .do_wb_i(do_wb_i), .wb_reg_i(wb_reg_i), .wb_val_i(wb_val_i),
      .wb_ready_o(wb_ready_o), .rf_grant_i(rf_grant_i), .do_wb_o(do_wb_o), .wb_reg_o(wb_reg_o),
      .wb_val_o(wb_val_o), .fwd_reg_i(fwd_reg_i), .fwd_hit_o(fwd_hit_o), .fwd_val_o(fwd_val_o),
      .count_o(count_o)
   );

   writeback_queue #(.DATA_W(32), .REG_W(5), .DEPTH(4), .ZERO_REG_DISCARD(0)) d0 (
      .clk_i(clk), .rst_i(rst_i), .do_wb_i(do_wb_i), .wb_reg_i(wb_reg_i), .wb_val_i(wb_val_i),
      .wb_ready_o(d0_ready), .rf_grant_i(rf_grant_i), .do_wb_o(d0_do_wb), .wb_reg_o(d0_reg),
      .wb_val_o(d0_val), .fwd_reg_i(fwd_reg_i), .fwd_hit_o(d0_hit), .fwd_val_o(d0_fval),
      .count_o(d0_count)
   );

   // Reference model of the DEPTH=4, discard-zero instance, advanced once per cycle
   always @(negedge clk) begin
      logic [2:0]  exp_c;
      logic        exp_hit;
      logic [31:0] exp_fv;
      ent_t        e;
      if (mon_en) begin
         exp_c = 3'(sb.size());
         n_total++;
         if (count_o !== exp_c) $display("FAIL mon_count got %0d want %0d", count_o, exp_c);
         else n_pass++;
         n_total++;
         if (wb_ready_o !== (exp_c < 3'd4)) $display("FAIL mon_ready got %0b want %0b", wb_ready_o, exp_c < 3'd4);
         else n_pass++;
         n_total++;
         if (do_wb_o !== (exp_c != 3'd0)) $display("FAIL mon_do_wb got %0b want %0b", do_wb_o, exp_c != 3'd0);
         else n_pass++;
         exp_hit = 1'b0;
         exp_fv  = '0;
         if (fwd_reg_i != 5'd0)
            foreach (sb[k]) if (sb[k].r == fwd_reg_i) begin exp_hit = 1'b1; exp_fv = sb[k].v; end
         n_total++;
         if (fwd_hit_o !== exp_hit || fwd_val_o !== exp_fv)
            $display("FAIL mon_fwd r%0d got %0b/%h want %0b/%h", fwd_reg_i, fwd_hit_o, fwd_val_o, exp_hit, exp_fv);
         else n_pass++;
         e = (exp_c == 3'd0) ? ent_t'(0) : sb[0];
         n_total++;
         if (wb_reg_o !== e.r || wb_val_o !== e.v)
            $display("FAIL mon_head got r%0d/%h want r%0d/%h", wb_reg_o, wb_val_o, e.r, e.v);
         else n_pass++;
         if (rst_i) sb.delete();
         else begin
            if (exp_c != 3'd0 && rf_grant_i) void'(sb.pop_front());
            if (do_wb_i && exp_c < 3'd4 && wb_reg_i != 5'd0) sb.push_back({wb_reg_i, wb_val_i});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; do_wb_i = 1'b0; rf_grant_i = 1'b0;
      cyc(); cyc();
      rst_i = 1'b0;
      n_total++;
      if (count_o !== 3'd0 || do_wb_o !== 1'b0 || wb_ready_o !== 1'b1)
         $display("FAIL reset_ctrl got cnt=%0d do=%0b rdy=%0b want 0/0/1", count_o, do_wb_o, wb_ready_o);
      else n_pass++;
      n_total++;
      if (wb_reg_o !== 5'd0 || wb_val_o !== 32'd0 || fwd_hit_o !== 1'b0 || fwd_val_o !== 32'd0)
         $display("FAIL reset_data got %0d/%h/%0b/%h want zeros", wb_reg_o, wb_val_o, fwd_hit_o, fwd_val_o);
      else n_pass++;
      mon_en = 1'b1;
   endtask

   task automatic test_pass_through();
      rf_grant_i = 1'b1;
      do_wb_i = 1'b1; wb_reg_i = 5'd3; wb_val_i = 32'h1111_1111;
      n_total++;
      if (do_wb_o !== 1'b0) $display("FAIL pt_no_bypass got %0b want 0", do_wb_o);
      else n_pass++;
      cyc();
      n_total++;
      if (do_wb_o !== 1'b1 || wb_reg_o !== 5'd3 || wb_val_o !== 32'h1111_1111)
         $display("FAIL pt_head_r3 got %0b/r%0d/%h want 1/r3/11111111", do_wb_o, wb_reg_o, wb_val_o);
      else n_pass++;
      wb_reg_i = 5'd4; wb_val_i = 32'h2222_2222;
      cyc();
      n_total++;
      if (count_o !== 3'd1 || wb_reg_o !== 5'd4 || wb_val_o !== 32'h2222_2222)
         $display("FAIL pt_head_r4 got cnt=%0d r%0d/%h want 1 r4/22222222", count_o, wb_reg_o, wb_val_o);
      else n_pass++;
      do_wb_i = 1'b0;
      cyc();
      n_total++;
      if (count_o !== 3'd0) $display("FAIL pt_drained got %0d want 0", count_o);
      else n_pass++;
   endtask

   task automatic test_fill();
      rf_grant_i = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         do_wb_i = 1'b1; wb_reg_i = 5'(i); wb_val_i = 32'(i);
         cyc();
      end
      wb_reg_i = 5'd5; wb_val_i = 32'd5;
      n_total++;
      if (wb_ready_o !== 1'b0 || count_o !== 3'd4)
         $display("FAIL fill_full got rdy=%0b cnt=%0d want 0/4", wb_ready_o, count_o);
      else n_pass++;
      cyc();
      n_total++;
      if (count_o !== 3'd4 || wb_reg_o !== 5'd1) $display("FAIL fill_held got cnt=%0d head=r%0d want 4/r1", count_o, wb_reg_o);
      else n_pass++;
      rf_grant_i = 1'b1;
      cyc();
      rf_grant_i = 1'b0;
      n_total++;
      if (count_o !== 3'd3 || wb_reg_o !== 5'd2 || wb_ready_o !== 1'b1)
         $display("FAIL fill_retire got cnt=%0d head=r%0d rdy=%0b want 3/r2/1", count_o, wb_reg_o, wb_ready_o);
      else n_pass++;
      cyc();
      do_wb_i = 1'b0;
      n_total++;
      if (count_o !== 3'd4) $display("FAIL fill_r5_in got %0d want 4", count_o);
      else n_pass++;
      rf_grant_i = 1'b1;
      repeat (4) cyc();
      rf_grant_i = 1'b0;
      n_total++;
      if (count_o !== 3'd0) $display("FAIL fill_drain got %0d want 0", count_o);
      else n_pass++;
   endtask

   task automatic test_forward();
      rf_grant_i = 1'b0;
      do_wb_i = 1'b1; wb_reg_i = 5'd7; wb_val_i = 32'hA; cyc();
      wb_reg_i = 5'd2; wb_val_i = 32'hB; cyc();
      wb_reg_i = 5'd7; wb_val_i = 32'hC; cyc();
      do_wb_i = 1'b0;
      fwd_reg_i = 5'd7; #1;
      n_total++;
      if (fwd_hit_o !== 1'b1 || fwd_val_o !== 32'hC) $display("FAIL fwd_r7 got %0b/%h want 1/c", fwd_hit_o, fwd_val_o);
      else n_pass++;
      fwd_reg_i = 5'd2; #1;
      n_total++;
      if (fwd_hit_o !== 1'b1 || fwd_val_o !== 32'hB) $display("FAIL fwd_r2 got %0b/%h want 1/b", fwd_hit_o, fwd_val_o);
      else n_pass++;
      fwd_reg_i = 5'd9; #1;
      n_total++;
      if (fwd_hit_o !== 1'b0 || fwd_val_o !== 32'h0) $display("FAIL fwd_r9 got %0b/%h want 0/0", fwd_hit_o, fwd_val_o);
      else n_pass++;
      fwd_reg_i = 5'd7;
      rf_grant_i = 1'b1;
      cyc(); cyc();
      n_total++;
      if (fwd_hit_o !== 1'b1 || fwd_val_o !== 32'hC) $display("FAIL fwd_last got %0b/%h want 1/c", fwd_hit_o, fwd_val_o);
      else n_pass++;
      cyc();
      rf_grant_i = 1'b0;
      n_total++;
      if (fwd_hit_o !== 1'b0 || fwd_val_o !== 32'h0) $display("FAIL fwd_drained got %0b/%h want 0/0", fwd_hit_o, fwd_val_o);
      else n_pass++;
   endtask

   task automatic test_zero_reg();
      rst_i = 1'b1; cyc(); rst_i = 1'b0;
      rf_grant_i = 1'b0;
      do_wb_i = 1'b1; wb_reg_i = 5'd0; wb_val_i = 32'hDEAD;
      cyc();
      do_wb_i = 1'b0; fwd_reg_i = 5'd0; #1;
      n_total++;
      if (count_o !== 3'd0 || do_wb_o !== 1'b0 || fwd_hit_o !== 1'b0)
         $display("FAIL zero_discard got cnt=%0d do=%0b hit=%0b want 0/0/0", count_o, do_wb_o, fwd_hit_o);
      else n_pass++;
      n_total++;
      if (d0_count !== 3'd1 || d0_do_wb !== 1'b1 || d0_reg !== 5'd0 || d0_val !== 32'hDEAD)
         $display("FAIL zero_keep got cnt=%0d do=%0b r%0d/%h want 1/1/r0/dead", d0_count, d0_do_wb, d0_reg, d0_val);
      else n_pass++;
      n_total++;
      if (d0_hit !== 1'b1 || d0_fval !== 32'hDEAD) $display("FAIL zero_keep_fwd got %0b/%h want 1/dead", d0_hit, d0_fval);
      else n_pass++;
      rf_grant_i = 1'b1; cyc(); rf_grant_i = 1'b0;
      n_total++;
      if (d0_count !== 3'd0 || d0_do_wb !== 1'b0) $display("FAIL zero_retire got cnt=%0d do=%0b want 0/0", d0_count, d0_do_wb);
      else n_pass++;
   endtask

   task automatic test_wrap();
      int  sent = 0;
      int  cycles = 0;
      bit  acc;
      bit  need_new = 1'b1;
      while (sent < 13 && cycles < 400) begin
         if (need_new) begin
            wb_reg_i = 5'($urandom_range(1, 7));
            wb_val_i = $urandom;
            need_new = 1'b0;
         end
         do_wb_i    = 1'b1;
         rf_grant_i = 1'($urandom_range(0, 1));
         fwd_reg_i  = 5'($urandom_range(0, 7));
         #1;
         acc = wb_ready_o;
         cyc();
         if (acc) begin sent++; need_new = 1'b1; end
         cycles++;
      end
      do_wb_i = 1'b0; rf_grant_i = 1'b1;
      cycles = 0;
      while (count_o != 3'd0 && cycles < 20) begin cyc(); cycles++; end
      rf_grant_i = 1'b0;
      n_total++;
      if (sent != 13) $display("FAIL wrap_timeout got %0d want 13", sent);
      else n_pass++;
      n_total++;
      if (count_o !== 3'd0 || sb.size() != 0) $display("FAIL wrap_drain got cnt=%0d sb=%0d want 0/0", count_o, sb.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      rf_grant_i = 1'b0;
      for (int i = 5; i <= 7; i++) begin
         do_wb_i = 1'b1; wb_reg_i = 5'(i); wb_val_i = 32'(i * 16);
         cyc();
      end
      do_wb_i = 1'b0;
      n_total++;
      if (count_o !== 3'd3) $display("FAIL rmid_pre got %0d want 3", count_o);
      else n_pass++;
      rst_i = 1'b1; cyc(); rst_i = 1'b0;
      n_total++;
      if (count_o !== 3'd0 || do_wb_o !== 1'b0 || wb_ready_o !== 1'b1 || wb_reg_o !== 5'd0 || wb_val_o !== 32'd0)
         $display("FAIL rmid_post got cnt=%0d do=%0b rdy=%0b r%0d/%h want 0/0/1/r0/0",
                  count_o, do_wb_o, wb_ready_o, wb_reg_o, wb_val_o);
      else n_pass++;
      rf_grant_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_total++;
         if (do_wb_o !== 1'b0) $display("FAIL rmid_stale cycle %0d got %0b want 0", i, do_wb_o);
         else n_pass++;
      end
      rf_grant_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_fill();
      test_forward();
      test_zero_reg();
      test_wrap();
      test_reset_mid();
      @(negedge clk);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
